uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Synthesizable UART receiver for the tinyQV peripheral set; the receive-side counterpart of the existing UART transmitter on uo_out[0].
- Samples the 2-FF-synchronised RXD line (8N1, LSB first) with a programmable divisor. Pushes good bytes into a small first-word-fall-through FIFO.
- Reports framing errors and overrun as sticky flags, which the CPU reads via the peripheral register interface.

Parameters:
- DIVISOR, 217, clk cycles per bit (25 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock (one clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial input, asynchronous to clk; idle high.
- rd_en  in  1  pop FIFO head this cycle; ignored when empty.
- rd_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a good byte arrived while the FIFO was full.
- clr_err  in  1  clears frame_err and overrun.
- busy  out  1  receiver state != IDLE.

Behaviour:
- Reset values:
  - sync flops = 1 (so no spurious start bit after reset).
  - state IDLE; bit counter and divider counter 0.
  - FIFO empty.
  - rd_data=0, rx_valid=0, fifo_full=0, frame_err=0, overrun=0, busy=0.
- Synchroniser: rxd -> s1 -> s2. Edge detection uses s2 and a registered copy s3. Start is detected when s3=1 and s2=0.
- Divider counter width is $clog2(DIVISOR).
- States:
  - IDLE: on start detect, load counter with DIVISOR/2-1, go to START.
  - START: at counter 0, sample s2. If s2=1 it was a glitch: return to IDLE, no flag. Otherwise load DIVISOR-1, bit index 0, go to DATA.
  - DATA: at counter 0, shift s2 into bit[index] (LSB first) and reload DIVISOR-1. After index 7, go to STOP.
  - STOP: at counter 0, sample s2.
    - s2=1: push byte, go to IDLE.
    - s2=0: set frame_err, drop byte, go to BREAK.
  - BREAK: wait until s2=1, then go to IDLE. A held-low line therefore yields exactly one frame_err and no repeated bytes.
- Latency: a pushed byte is visible (rx_valid=1, rd_data) on the cycle after the stop-bit sample. That sample is taken mid-stop-bit, about DIVISOR/2+2 cycles after the stop-bit start edge, including the 2-cycle sync delay.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge immediately after the stop bit is caught without loss.
- FIFO:
  - rd_data is driven from the head entry (first-word-fall-through).
  - Pop occurs when rd_en=1 and not empty.
  - Push when full and no pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both performed, no overrun, occupancy unchanged.
  - Push and pop in the same cycle while empty: push only; rd_en is ignored that cycle.
  - Pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit. full/empty derive from the pointer compare.
- Sticky flags: clr_err clears both flags. If clr_err coincides with a new error event, the set wins.
- Asynchronous reset mid-frame aborts the frame immediately and empties the FIFO. After release, the receiver waits for a fresh falling edge; no partial byte is ever pushed.
- busy=1 in START, DATA, STOP and BREAK.

Decomposition:
- Shared package tqv_uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - DEFAULT_DIVISOR=217.
  - UART_DATA_BITS=8.
- Sub-module uart_rx_fifo, parameter FIFO_DEPTH.
  - Ports: clk, rst_n, push, push_data, pop, head, empty, full, overflow_pulse.
  - Holds the pointer logic and the simultaneous push/pop rules.
  - The top level contains the synchroniser, the FSM, the divider and the sticky flags.

Test Plan:
- Drive 'O' (0x4F), 'K' (0x4B), 0x0A back-to-back at 217 clks/bit -> rx_valid rises after the first frame. Three pops read 0x4F, 0x4B, 0x0A in order. frame_err=0, overrun=0.
- Pulse rxd low for 50 clks from idle -> START rejects it, busy returns to 0, rx_valid stays 0, frame_err stays 0.
- Send 0xA5 with the stop bit held low for 300 clks, then idle, then send 0x31 -> frame_err=1 and 0xA5 is not stored. 0x31 is received correctly. clr_err clears frame_err.
- Send 5 bytes 0x10..0x14 with no reads -> fifo_full=1 after the 4th byte, overrun=1 after the 5th. Pops return 0x10..0x13 only.
- FIFO full, 5th stop-bit sample coincides with rd_en=1 -> 0x10 is popped, 0x14 is stored, overrun stays 0, fifo_full stays 1.
- Assert rst_n=0 mid-DATA of 0x55, release, then send 0x7E -> only 0x7E is received. No flags are set, and no spurious byte appears after reset.

Source files
------------

// File: rtl/tqv_uart_pkg.sv
// rtl/tqv_uart_pkg.sv - shared types and constants for the tinyQV UART blocks
package tqv_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_DIVISOR = 217;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO for uart_rx
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write a byte (dropped when full unless popped this cycle)
//   pop             remove head entry; ignored when empty
//   head            current head entry (meaningful only while !empty)
//   empty, full     occupancy status from the pointer compare
//   overflow_pulse  one-cycle pulse when a push was dropped
module uart_rx_fifo
    import tqv_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]               wr_ptr_q, wr_ptr_d;
    logic [AW:0]               rd_ptr_q, rd_ptr_d;
    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [UART_DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic                      do_push;
    logic                      do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot but different lap: the writer is a full buffer ahead.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop while full frees the slot the simultaneous push lands in;
    // a pop while empty is ignored so a same-cycle push simply lands.
    assign do_pop         = pop & ~empty;
    assign do_push        = push & (~full | do_pop);
    assign overflow_pulse = push & full & ~do_pop;

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with FWFT receive FIFO and sticky error flags
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rxd         raw serial input (asynchronous, idle high)
//   rd_en       pop the FIFO head
//   rd_data     FIFO head byte, valid while rx_valid
//   rx_valid    FIFO non-empty
//   fifo_full   FIFO holds FIFO_DEPTH bytes
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: good byte dropped because FIFO was full
//   clr_err     clears both sticky flags (a coincident new error wins)
//   busy        receiver is inside a frame (or waiting out a break)
module uart_rx
    import tqv_uart_pkg::*;
#(
    parameter int DIVISOR    = DEFAULT_DIVISOR,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      rx_valid,
    output logic                      fifo_full,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      clr_err,
    output logic                      busy
);

    localparam int CW = $clog2(DIVISOR);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    logic                      s1_q, s1_d;
    logic                      s2_q, s2_d;
    logic                      s3_q, s3_d;
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    logic                      start_det;
    logic                      tick;
    logic                      push;
    logic                      fe_event;
    logic                      fifo_empty;
    logic                      overflow_pulse;

    // s3 is a delayed copy of s2 so a falling edge shows as s3=1, s2=0.
    always_comb begin
        s1_d = rxd;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign start_det = s3_q & ~s2_q;
    assign tick      = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        fe_event  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    // Half a bit lands the first sample mid start bit.
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (s2_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[bit_idx_q] = s2_q;
                    cnt_d              = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (s2_q) begin
                    // Leaving mid stop bit keeps back-to-back start edges visible.
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    fe_event = 1'b1;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                // Hold off until the line recovers so a long low is one error.
                if (s2_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Set has priority over clear so a coincident error is never lost.
    always_comb begin
        frame_err_d = (frame_err_q & ~clr_err) | fe_event;
        overrun_d   = (overrun_q & ~clr_err) | overflow_pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (shift_q),
        .pop           (rd_en),
        .head          (rd_data),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .overflow_pulse(overflow_pulse)
    );

    assign rx_valid  = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV   = 217;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       exp_fe = 1'b0;
    logic       exp_ov = 1'b0;

    uart_rx #(
        .DIVISOR   (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .fifo_full(fifo_full),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame on the wire; stop_low>0 holds the stop bit low that many clocks first.
    task automatic drive_frame(input logic [7:0] b, input int stop_low);
        rxd = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(DIV);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            idle(stop_low);
        end
        rxd = 1'b1;
        idle(DIV);
    endtask

    // Reference: a good byte joins the queue if there is room, else overrun.
    function automatic void model_good(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      exp_ov = 1'b1;
    endfunction

    task automatic send_good(input logic [7:0] b);
        drive_frame(b, 0);
        model_good(b);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, rx_valid, (exp_q.size() != 0));
        check({tag, "_full"}, fifo_full, (exp_q.size() == DEPTH));
        check({tag, "_ferr"}, frame_err, exp_fe);
        check({tag, "_ovr"}, overrun, exp_ov);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, rx_valid, 1'b0);
        end else begin
            check({tag, "_valid"}, rx_valid, 1'b1);
            check({tag, "_data"}, rd_data, exp_q[0]);
            rd_en = 1'b1;
            idle(1);
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic pop_all(input string tag);
        while (exp_q.size() != 0) pop_one(tag);
        check({tag, "_drained"}, rx_valid, 1'b0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        exp_fe  = 1'b0;
        exp_ov  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        rst_n   = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        idle(5);
        check("reset_rd_data", rd_data, 8'h00);
        check_state("reset");
        rst_n = 1'b1;
        idle(5);

        // Back-to-back frames
        send_good(8'h4F);
        check("first_valid", rx_valid, 1'b1);
        send_good(8'h4B);
        send_good(8'h0A);
        check_state("b2b");
        pop_one("b2b_pop0");
        pop_one("b2b_pop1");
        pop_one("b2b_pop2");
        check_state("b2b_after");

        // Pop while empty is ignored
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        check_state("pop_empty");

        // Short glitch rejected in START
        rxd = 1'b0;
        idle(10);
        check("glitch_busy", busy, 1'b1);
        idle(40);
        rxd = 1'b1;
        idle(DIV);
        check_state("glitch");

        // Framing error with a long low stop bit, then recovery
        drive_frame(8'hA5, 300);
        exp_fe = 1'b1;
        check_state("ferr");
        send_good(8'h31);
        check_state("ferr_next");
        pop_one("ferr_pop");
        pulse_clr();
        check_state("ferr_clr");

        // Overrun: five bytes, no reads
        for (int i = 0; i < 5; i++) begin
            send_good(8'h10 + 8'(i));
            if (i == 3) check_state("fill4");
        end
        check_state("ovr");
        pop_all("ovr_pop");
        pulse_clr();
        check_state("ovr_clr");

        // Full FIFO, pop coinciding with the fifth stop-bit sample
        for (int i = 0; i < 4; i++) send_good(8'h10 + 8'(i));
        check_state("coinc_full");
        fork
            drive_frame(8'h14, 0);
            begin
                // Stop sample lands on the 2064th rising edge after the start edge.
                idle(2063);
                rd_en = 1'b1;
                idle(1);
                rd_en = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        model_good(8'h14);
        check_state("coinc");
        pop_all("coinc_pop");

        // Reset mid-DATA empties the FIFO and aborts the frame
        send_good(8'h22);
        rxd = 1'b0;
        idle(DIV);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0] ? 1'b0 : 1'b1;
            idle(DIV);
        end
        idle(50);
        rst_n = 1'b0;
        rxd   = 1'b1;
        exp_q.delete();
        idle(5);
        check_state("rst_mid");
        rst_n = 1'b1;
        idle(2 * DIV);
        check_state("rst_rel");
        send_good(8'h7E);
        check_state("rst_next");
        pop_all("rst_pop");

        // Random bytes with random gaps and reads
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 50));
            send_good(b);
            check_state("rand");
            if ($urandom_range(0, 1) == 1) pop_all("rand_pop");
        end
        pop_all("rand_end");
        pulse_clr();
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
